// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out front end.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit-counter width for a WIDTH-bit word.
  function automatic int unsigned CNT_W(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serializes WIDTH-bit words onto a registered one-bit line, gapless under continuous in_valid.
// Build option: define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             word_done
);

`ifdef PISO_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam int unsigned     CntW    = CNT_W(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             serial_q, serial_d;
  logic             sval_q, sval_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt_q == CntLast);
  assign accept   = in_valid & in_ready;

  // Ready depends only on state/count so upstream never sees a combinational loop.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:    in_ready = 1'b1;
        SHIFT:   in_ready = !ParityEn && last_bit;
        PARITY:  in_ready = ParityEn;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        if (!last_bit) begin
          cnt_d  = cnt_q + CntW'(1);
          sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        end else begin
          state_d = ParityEn ? PARITY : IDLE;
        end
      end
      PARITY:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = in_data;
      cnt_d   = '0;
      par_d   = ^in_data;
    end
  end

  // Line outputs are derived from next state so they register alongside it.
  always_comb begin
    serial_d = IDLE_BIT;
    sval_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      SHIFT: begin
        serial_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
        sval_d   = 1'b1;
        done_d   = !ParityEn && (cnt_d == CntLast);
      end
      PARITY: begin
        serial_d = par_d;
        sval_d   = 1'b1;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      serial_q <= IDLE_BIT;
      sval_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      sval_q   <= sval_d;
      done_q   <= done_d;
    end
  end

  assign serial_out   = serial_q;
  assign serial_valid = sval_q;
  assign word_done    = done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first/IDLE_BIT=0 and an LSB-first/IDLE_BIT=1 instance
// checked against a queue-of-pending-bits model.
module tb_piso_serializer;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif
  localparam int Frame = W + (Par ? 1 : 0);
  localparam logic [31:0] FrameMask = (32'd1 << Frame) - 32'd1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         rdy_a, ser_a, sv_a, busy_a, done_a;
  logic         rdy_b, ser_b, sv_b, busy_b, done_b;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .serial_out(ser_a), .serial_valid(sv_a), .busy(busy_a), .word_done(done_a)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
    .serial_out(ser_b), .serial_valid(sv_b), .busy(busy_b), .word_done(done_b)
  );

  int checks = 0;
  int passes = 0;

  // Each model entry is {last_of_frame, bit}; the line shows cur_* and the queues hold the rest.
  logic [1:0]  qa[$];
  logic [1:0]  qb[$];
  logic        cur_v = 1'b0;
  logic [1:0]  cur_a = 2'b00;
  logic [1:0]  cur_b = 2'b00;
  logic [31:0] bits_a = '0;
  logic [31:0] bits_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    logic last;
    for (int i = 0; i < W; i++) begin
      last = (i == W - 1) && !Par;
      qa.push_back({last, w[W-1-i]});
      qb.push_back({last, w[i]});
    end
    if (Par) begin
      qa.push_back({1'b1, ^w});
      qb.push_back({1'b1, ^w});
    end
  endtask

  task automatic check_out();
    chk("serial_a", 32'(ser_a), 32'(cur_v ? cur_a[0] : 1'b0));
    chk("serial_b", 32'(ser_b), 32'(cur_v ? cur_b[0] : 1'b1));
    chk("svalid_a", 32'(sv_a), 32'(cur_v));
    chk("svalid_b", 32'(sv_b), 32'(cur_v));
    chk("done_a", 32'(done_a), 32'(cur_v & cur_a[1]));
    chk("done_b", 32'(done_b), 32'(cur_v & cur_b[1]));
    chk("busy_a", 32'(busy_a), 32'(cur_v));
    chk("busy_b", 32'(busy_b), 32'(cur_v));
  endtask

  // One clock: drive inputs just after negedge, check ready, advance model at posedge,
  // check line outputs at the following negedge.
  task automatic step(input logic v, input logic [W-1:0] d);
    logic acc;
    in_valid = v;
    in_data  = d;
    #1;
    chk("in_ready_a", 32'(rdy_a), 32'(qa.size() == 0));
    chk("in_ready_b", 32'(rdy_b), 32'(qb.size() == 0));
    acc = v && (qa.size() == 0);
    @(posedge clk);
    if (acc) push_word(d);
    if (qa.size() > 0) begin
      cur_v = 1'b1;
      cur_a = qa.pop_front();
      cur_b = qb.pop_front();
    end else begin
      cur_v = 1'b0;
    end
    @(negedge clk);
    check_out();
    bits_a = {bits_a[30:0], ser_a};
    bits_b = {bits_b[30:0], ser_b};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_serial_a", 32'(ser_a), 32'(1'b0));
    chk("rst_serial_b", 32'(ser_b), 32'(1'b1));
    chk("rst_svalid", 32'({sv_a, sv_b}), 32'(2'b00));
    chk("rst_busy", 32'({busy_a, busy_b}), 32'(2'b00));
    chk("rst_done", 32'({done_a, done_b}), 32'(2'b00));
    chk("rst_ready", 32'({rdy_a, rdy_b}), 32'(2'b00));
    qa.delete();
    qb.delete();
    cur_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic word(input string tag, input logic [W-1:0] w,
                      input logic [31:0] exp_a, input logic [31:0] exp_b);
    step(1'b1, w);
    repeat (Frame - 1) step(1'b0, 8'($urandom));
    chk({tag, "_bits_a"}, bits_a & FrameMask, exp_a);
    chk({tag, "_bits_b"}, bits_b & FrameMask, exp_b);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    chk("init_serial_a", 32'(ser_a), 32'(1'b0));
    chk("init_serial_b", 32'(ser_b), 32'(1'b1));
    chk("init_flags", 32'({sv_a, busy_a, done_a, rdy_a}), 32'(4'b0000));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single words from idle; expected frames are first-bit-leftmost.
    if (Par) begin
      word("w6a", 8'h6A, 32'h0D4, 32'h0AC);
      word("w07", 8'h07, 32'h00F, 32'h1C1);
      word("w01", 8'h01, 32'h003, 32'h101);
    end else begin
      word("w6a", 8'h6A, 32'h6A, 32'h56);
      word("w07", 8'h07, 32'h07, 32'hE0);
      word("w01", 8'h01, 32'h01, 32'h80);
    end
    step(1'b0, 8'h00);
    chk("idle_after_b", 32'(ser_b), 32'(1'b1));
    chk("idle_after_a", 32'(ser_a), 32'(1'b0));

    // Back-to-back with in_valid held high and in_data changing while not ready.
    step(1'b1, 8'hA5);
    repeat (Frame - 1) step(1'b1, 8'($urandom));
    step(1'b1, 8'h3C);
    repeat (Frame - 1) step(1'b1, 8'($urandom));
    if (Par) begin
      chk("b2b_a", bits_a & 32'h3FFFF, 32'h29478);
      chk("b2b_b", bits_b & 32'h3FFFF, 32'h29478);
    end else begin
      chk("b2b_a", bits_a & 32'hFFFF, 32'hA53C);
      chk("b2b_b", bits_b & 32'hFFFF, 32'hA53C);
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);

    // Reset in the middle of a word, then a fresh word.
    step(1'b1, 8'hFF);
    repeat (3) step(1'b0, 8'h00);
    do_reset();
    if (Par) word("after_rst", 8'h5A, 32'h0B4, 32'h0B4);
    else word("after_rst", 8'h5A, 32'h5A, 32'h5A);

    // Random traffic with occasional resets.
    repeat (400) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else step(r < 75, 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out front end for the serial pattern-detector path. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial line. The line feeds the downstream Mealy sequence detector's serial input directly. Back-to-back words stream with no idle gap, so multi-word patterns spanning word boundaries reach the detector contiguously.

## Interface
- WIDTH, 8, word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- IDLE_BIT, 0, serial_out level when no word is being sent
- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, asynchronous, active-high; clock clk
- in_data  input  WIDTH  word to serialize, sampled on accept
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- serial_out  output  1  registered serial bit
- serial_valid  output  1  serial_out carries a data (or parity) bit
- busy  output  1  word in flight (state ≠ IDLE)
- word_done  output  1  one-cycle pulse coincident with last emitted bit of a word

## Operation
- Accept = in_valid & in_ready at a rising edge. The word is copied into shift register sreg, and counter cnt is cleared.
- States:
  - IDLE: serial_out = IDLE_BIT, serial_valid = 0.
  - SHIFT: emits one bit per cycle, cnt 0..WIDTH-1.
  - PARITY: only with the macro; see Configuration.
- Transitions:
  - IDLE→SHIFT on accept.
  - SHIFT at cnt = WIDTH-1 goes to SHIFT again if accept (reload, cnt=0), otherwise to PARITY (macro) or IDLE.
  - PARITY→SHIFT on accept, else IDLE.
- in_ready is combinational from state and cnt only, never from in_valid. It is high in IDLE, in SHIFT at cnt = WIDTH-1 (macro off), and in PARITY (macro on). It is low during reset.
- in_data is not re-sampled after accept. Upstream may change it freely once accepted.
- word_done is registered and is high exactly in the cycle the final bit (last data bit, or parity bit) is on serial_out.
- busy = (state ≠ IDLE).

## Timing
- Reset values: serial_out = IDLE_BIT, serial_valid = 0, busy = 0, word_done = 0, state = IDLE, sreg = 0, cnt = 0.
- Latency: the first bit appears on serial_out in the cycle after the accepting edge.
- A word occupies WIDTH cycles (WIDTH+1 with the macro).
- Continuous in_valid gives a fully gapless stream: serial_valid stays high indefinitely.
- An in_valid gap returns the block to IDLE for at least one cycle, with serial_out = IDLE_BIT in that cycle.
- Reset asserted mid-word aborts the word immediately (asynchronous). Remaining bits are discarded, no word_done is produced, and the block restarts in IDLE.
- in_valid asserted while in_ready is low has no effect. The word is held upstream until in_ready rises.

## Configuration
- PISO_PARITY_EN defined:
  - After the WIDTH data bits, one even-parity bit (XOR of the accepted word) is emitted with serial_valid = 1.
  - word_done fires on the parity cycle.
  - in_ready is high in the PARITY state, not at cnt = WIDTH-1.
- PISO_PARITY_EN undefined:
  - No PARITY state exists.
  - Word period is exactly WIDTH cycles.
  - in_ready is high at cnt = WIDTH-1.

## Structure
- Shared package piso_pkg holds:
  - typedef enum state_t {IDLE, SHIFT, PARITY}
  - function clog2-based CNT_W(WIDTH) for the counter width.
- Single module; no sub-module is natural. The parity XOR and shift mux are a few lines each.

## Test plan
- WIDTH=8, MSB_FIRST=1, accept 8'h6A at edge 0 → serial_out = 0,1,1,0,1,0,1,0 in cycles 1–8. word_done is high in cycle 8 only. The downstream detector flags 0110 and 1010.
- Back-to-back 8'hA5 then 8'h3C with in_valid held high → 16 consecutive cycles with serial_valid = 1, and bits 10100101 00111100. in_ready is high only in cycles 8 and 16.
- MSB_FIRST=0, 8'h01 → first emitted bit 1, then seven 0s. serial_out = IDLE_BIT on cycle 9 when no new word arrives.
- Reset asserted in cycle 4 of 8'hFF → serial_out = IDLE_BIT and serial_valid = 0 immediately. No word_done. The next accept after reset starts a fresh word from cnt = 0.
- PISO_PARITY_EN, 8'h6A → 9-bit frame ending in parity 0. 8'h07 → parity 1. word_done is on cycle 9. A second word accepted in the parity cycle starts gaplessly.
- in_valid high while in_ready is low (mid-word), with in_data changing each cycle → no extra accept. The word captured is the value present at the in_ready-high edge.
